// File: rtl/cpipe1_stage.sv
`default_nettype none
// ============================================================================
// Module   : cpipe1_stage
// Brief    : Control-pipeline stage-1 opcode register with reset sequencing,
//            one-entry skid buffer, flush bubble injection and flush counter.
// Revision : 1.0 - initial release
// ============================================================================
module cpipe1_stage #(
    parameter int            OPW           = 8,
    parameter logic [OPW-1:0] NOP_OP       = 8'h20,
    parameter int            RST_CYCLES    = 4,
    parameter int            FLUSH_BUBBLES = 2,
    parameter int            CNTW          = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            WAIT,
    input  logic            instr_valid,
    input  logic [OPW-1:0]  instr_op,
    output logic            instr_ready,
    input  logic            CPIPE1load1,
    input  logic            CPIPE1flush,
    input  logic            trap,
    output logic [OPW-1:0]  CPIPE1s,
    output logic            cpipe1_valid,
    output logic [CNTW-1:0] flush_events
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] c_rst_cnt   = 4'(RST_CYCLES - 1);
    localparam logic [3:0] c_flush_cnt = 4'(FLUSH_BUBBLES - 1);

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_skid_full;
    logic [OPW-1:0]  r_skid_data;
    logic [OPW-1:0]  r_op;
    logic            r_valid;
    logic [CNTW-1:0] r_flush_events;

    logic w_accept;
    logic w_flush;
    logic w_adv;

    assign instr_ready  = (r_state == S_RUN) & ~r_skid_full;
    assign w_accept     = instr_valid & instr_ready;
    assign w_flush      = (CPIPE1flush | trap) & ~WAIT;
    assign w_adv        = ~WAIT & CPIPE1load1;

    assign CPIPE1s      = r_op;
    assign cpipe1_valid = r_valid;
    assign flush_events = r_flush_events;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state        <= S_INIT;
            r_cnt          <= c_rst_cnt;
            r_skid_full    <= 1'b0;
            r_skid_data    <= NOP_OP;
            r_op           <= NOP_OP;
            r_valid        <= 1'b0;
            r_flush_events <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    // Countdown deliberately ignores WAIT so startup length is fixed.
                    r_op    <= NOP_OP;
                    r_valid <= 1'b0;
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RUN: begin
                    if (w_flush) begin
                        r_op        <= NOP_OP;
                        r_valid     <= 1'b0;
                        r_skid_full <= 1'b0;
                        if (~&r_flush_events) begin
                            r_flush_events <= r_flush_events + 1'b1;
                        end
                        r_state <= S_FLUSH;
                        r_cnt   <= c_flush_cnt;
                    end else if (w_adv) begin
                        if (r_skid_full) begin
                            r_op        <= r_skid_data;
                            r_valid     <= 1'b1;
                            r_skid_full <= 1'b0;
                        end else if (w_accept) begin
                            r_op    <= instr_op;
                            r_valid <= 1'b1;
                        end else begin
                            r_op    <= NOP_OP;
                            r_valid <= 1'b0;
                        end
                    end else if (w_accept) begin
                        // Stalled or decoder holding: park the opcode in the skid.
                        r_skid_data <= instr_op;
                        r_skid_full <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_op    <= NOP_OP;
                    r_valid <= 1'b0;
                    if (~WAIT) begin
                        if (r_cnt == 4'd0) begin
                            r_state <= S_RUN;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_INIT;
                    r_cnt   <= c_rst_cnt;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpipe1_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpipe1_stage
// Brief    : Self-checking bench for cpipe1_stage: directed scenarios plus
//            randomized traffic against a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpipe1_stage;

    localparam int         OPW   = 8;
    localparam logic [7:0] NOP   = 8'h20;
    localparam int         RSTC  = 4;
    localparam int         FLB   = 2;
    // Narrow counter so saturation is reachable within a short run.
    localparam int         CNTW  = 5;
    localparam int         FEMAX = (1 << CNTW) - 1;

    logic            CLK = 1'b0;
    logic            RESET, WAIT, instr_valid, instr_ready;
    logic [OPW-1:0]  instr_op;
    logic            CPIPE1load1, CPIPE1flush, trap;
    logic [OPW-1:0]  CPIPE1s;
    logic            cpipe1_valid;
    logic [CNTW-1:0] flush_events;

    int checks   = 0;
    int failures = 0;

    cpipe1_stage #(
        .OPW(OPW), .NOP_OP(NOP), .RST_CYCLES(RSTC),
        .FLUSH_BUBBLES(FLB), .CNTW(CNTW)
    ) dut (
        .CLK(CLK), .RESET(RESET), .WAIT(WAIT),
        .instr_valid(instr_valid), .instr_op(instr_op), .instr_ready(instr_ready),
        .CPIPE1load1(CPIPE1load1), .CPIPE1flush(CPIPE1flush), .trap(trap),
        .CPIPE1s(CPIPE1s), .cpipe1_valid(cpipe1_valid), .flush_events(flush_events)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: phase + cycles-left bookkeeping, skid as a queue.
    localparam int M_INIT = 0, M_RUN = 1, M_FLUSH = 2;
    int         m_mode = M_INIT;
    int         m_left = RSTC;
    logic [7:0] m_q[$];
    logic [7:0] m_out = NOP;
    logic       m_valid = 1'b0;
    int         m_fe = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the current inputs, then compare.
    task automatic step();
        bit rdy;
        bit acc;
        rdy = (m_mode == M_RUN) && (m_q.size() == 0);
        acc = instr_valid && rdy;
        if (RESET) begin
            m_mode = M_INIT; m_left = RSTC; m_q.delete();
            m_out = NOP; m_valid = 1'b0; m_fe = 0;
        end else if (m_mode == M_INIT) begin
            m_out = NOP; m_valid = 1'b0;
            m_left--;
            if (m_left == 0) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if ((CPIPE1flush || trap) && !WAIT) begin
                m_q.delete(); m_out = NOP; m_valid = 1'b0;
                if (m_fe < FEMAX) m_fe++;
                m_mode = M_FLUSH; m_left = FLB;
            end else if (!WAIT && CPIPE1load1) begin
                if (m_q.size() != 0) begin
                    m_out = m_q.pop_front(); m_valid = 1'b1;
                end else if (acc) begin
                    m_out = instr_op; m_valid = 1'b1;
                end else begin
                    m_out = NOP; m_valid = 1'b0;
                end
            end else if (acc) begin
                m_q.push_back(instr_op);
            end
        end else begin
            if (!WAIT) begin
                m_left--;
                if (m_left == 0) m_mode = M_RUN;
            end
        end
        @(posedge CLK);
        #1;
        chk("CPIPE1s", 32'(CPIPE1s), 32'(m_out));
        chk("cpipe1_valid", 32'(cpipe1_valid), 32'(m_valid));
        chk("flush_events", 32'(flush_events), 32'(m_fe));
        chk("instr_ready", 32'(instr_ready),
            32'((m_mode == M_RUN) && (m_q.size() == 0)));
    endtask

    task automatic idle_inputs();
        WAIT = 0; instr_valid = 0; instr_op = 8'h00;
        CPIPE1load1 = 1; CPIPE1flush = 0; trap = 0;
    endtask

    initial begin
        RESET = 1;
        idle_inputs();
        #1;
        step(); step();
        chk("rst_op", 32'(CPIPE1s), 32'h20);
        chk("rst_ready", 32'(instr_ready), 32'h0);
        chk("rst_fe", 32'(flush_events), 32'h0);

        // Startup countdown: 4 NOP cycles after release, ready on the 5th.
        RESET = 0;
        for (int i = 0; i < 3; i++) begin
            chk("init_ready", 32'(instr_ready), 32'h0);
            chk("init_op", 32'(CPIPE1s), 32'h20);
            step();
        end
        chk("init_ready4", 32'(instr_ready), 32'h0);
        step();
        chk("run_ready5", 32'(instr_ready), 32'h1);

        // Zero-latency pass-through.
        instr_valid = 1; instr_op = 8'h81; step();
        chk("pass_81", 32'(CPIPE1s), 32'h81);
        chk("pass_v", 32'(cpipe1_valid), 32'h1);
        instr_op = 8'h89; step();
        chk("pass_89", 32'(CPIPE1s), 32'h89);
        instr_valid = 0; step();
        chk("pass_bubble", 32'(CPIPE1s), 32'h20);

        // Accept under WAIT goes to skid; released when WAIT drops.
        WAIT = 1; instr_valid = 1; instr_op = 8'hA4; step();
        chk("wait_ready", 32'(instr_ready), 32'h0);
        chk("wait_frozen", 32'(CPIPE1s), 32'h20);
        instr_valid = 0; step();
        chk("wait_frozen2", 32'(CPIPE1s), 32'h20);
        WAIT = 0; step();
        chk("skid_a4", 32'(CPIPE1s), 32'hA4);

        // Flush while skid is full: skid contents dropped.
        CPIPE1load1 = 0; instr_valid = 1; instr_op = 8'h55; step();
        instr_valid = 0; CPIPE1flush = 1; step();
        chk("fl_op", 32'(CPIPE1s), 32'h20);
        chk("fl_fe", 32'(flush_events), 32'h1);
        chk("fl_ready", 32'(instr_ready), 32'h0);
        CPIPE1flush = 0; step();
        chk("fl_ready2", 32'(instr_ready), 32'h0);
        step();
        chk("fl_resume", 32'(instr_ready), 32'h1);
        CPIPE1load1 = 1; step();
        chk("fl_dropped", 32'(cpipe1_valid), 32'h0);

        // Trap held off by WAIT, then taken once.
        trap = 1; WAIT = 1; step(); step();
        chk("trap_held", 32'(flush_events), 32'h1);
        WAIT = 0; step();
        chk("trap_taken", 32'(flush_events), 32'h2);
        step();
        chk("trap_once", 32'(flush_events), 32'h2);
        trap = 0; step(); step();

        // Saturation, then reset in the middle of a flush.
        for (int i = 0; i < FEMAX + 4; i++) begin
            CPIPE1flush = 1; step();
            CPIPE1flush = 0; step(); step();
        end
        chk("sat_fe", 32'(flush_events), 32'h1F);
        CPIPE1flush = 1; step();
        chk("sat_hold", 32'(flush_events), 32'h1F);
        CPIPE1flush = 0; RESET = 1; step();
        chk("midrst_fe", 32'(flush_events), 32'h0);
        chk("midrst_ready", 32'(instr_ready), 32'h0);
        RESET = 0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            RESET       = ($urandom_range(0, 299) == 0);
            WAIT        = ($urandom_range(0, 3) == 0);
            instr_valid = $urandom_range(0, 1);
            instr_op    = 8'($urandom);
            CPIPE1load1 = ($urandom_range(0, 3) != 0);
            CPIPE1flush = ($urandom_range(0, 15) == 0);
            trap        = ($urandom_range(0, 31) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
